// File: rtl/dino_pkg.sv
// dino_pkg: shared screen geometry, scroll format and run-state encoding for the Dino VGA pipeline.
package dino_pkg;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int GND_LINE  = 200;
  localparam int TILE_W    = 32;
  localparam int FRAC_BITS = 2;
  typedef enum logic {ST_IDLE, ST_RUN} run_state_t;
endpackage

// File: rtl/bg_scroll_acc.sv
// bg_scroll_acc: frame-edge detector, run state and sub-pixel scroll accumulator.
module bg_scroll_acc import dino_pkg::*; #(
  parameter int TILE_W    = dino_pkg::TILE_W,
  parameter int FRAC_BITS = dino_pkg::FRAC_BITS,
  parameter int SPEED_W   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_frame_tick,
  input  logic                      i_run,
  input  logic                      i_restart,
  input  logic [SPEED_W-1:0]        i_speed,
  output logic [$clog2(TILE_W)-1:0] o_scroll
);
  localparam int SW    = $clog2(TILE_W);
  localparam int ACC_W = SW + FRAC_BITS;
  logic             tick_q;
  logic             tick_edge;
  run_state_t       state;
  logic [ACC_W-1:0] acc;
  assign tick_edge = i_frame_tick & ~tick_q;
  assign o_scroll  = acc[ACC_W-1:FRAC_BITS];
  // tick_q resets high so a tick already asserted at release is not an edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_q <= 1'b1;
      state  <= ST_IDLE;
      acc    <= '0;
    end else begin
      tick_q <= i_frame_tick;
      if (i_restart) begin
        state <= ST_IDLE;
        acc   <= '0;
      end else begin
        state <= i_run ? ST_RUN : ST_IDLE;
        if (tick_edge && state == ST_RUN) acc <= acc + ACC_W'(i_speed);
      end
    end
  end
endmodule

// File: rtl/bg_ground.sv
// bg_ground: scrolling horizon row plus optional pebble band (BG_GROUND_TEXTURE_EN), registered pixel.
module bg_ground import dino_pkg::*; #(
  parameter int                    CONV        = 0,
  parameter int                    GND_LINE    = dino_pkg::GND_LINE,
  parameter int                    TILE_W      = dino_pkg::TILE_W,
  parameter int                    FRAC_BITS   = dino_pkg::FRAC_BITS,
  parameter int                    SPEED_W     = 5,
  parameter logic [2*TILE_W-1:0]   PEBBLE_MASK = 64'h0000_0420_0000_0020
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [9:CONV]             i_hpos,
  input  logic [9:CONV]             i_vpos,
  input  logic                      i_frame_tick,
  input  logic                      i_run,
  input  logic                      i_restart,
  input  logic [SPEED_W-1:0]        i_speed,
  output logic                      o_color_bg,
  output logic [$clog2(TILE_W)-1:0] o_scroll
);
  localparam int VW = 10 - CONV;
  localparam int SW = $clog2(TILE_W);
  localparam logic [VW-1:0] LINE = VW'(GND_LINE);
  logic          pix;
  logic          unused_bits;
  bg_scroll_acc #(
    .TILE_W   (TILE_W),
    .FRAC_BITS(FRAC_BITS),
    .SPEED_W  (SPEED_W)
  ) u_acc (
    .clk         (clk),
    .rst         (rst),
    .i_frame_tick(i_frame_tick),
    .i_run       (i_run),
    .i_restart   (i_restart),
    .i_speed     (i_speed),
    .o_scroll    (o_scroll)
  );
  assign unused_bits = ^{i_hpos, PEBBLE_MASK};
`ifdef BG_GROUND_TEXTURE_EN
  logic [SW-1:0] u;
  assign u = i_hpos[CONV +: SW] + o_scroll;
  always_comb begin
    pix = (i_vpos == LINE)
        | ((i_vpos == LINE + VW'(1)) & PEBBLE_MASK[u])
        | ((i_vpos == LINE + VW'(2)) & PEBBLE_MASK[TILE_W + int'(u)]);
  end
`else
  always_comb begin
    pix = (i_vpos == LINE);
  end
`endif
  always_ff @(posedge clk) begin
    if (!rst) o_color_bg <= 1'b0;
    else      o_color_bg <= pix;
  end
endmodule

// File: tb/tb_bg_ground.sv
// tb_bg_ground: directed self-checking bench for bg_ground (texture expectations follow BG_GROUND_TEXTURE_EN).
module tb_bg_ground;
  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hpos, vpos;
  logic       tick, run, restart;
  logic [4:0] speed;
  logic       color;
  logic [4:0] scroll;
  int         checks = 0;
  int         failures = 0;
`ifdef BG_GROUND_TEXTURE_EN
  localparam logic TEX = 1'b1;
`else
  localparam logic TEX = 1'b0;
`endif
  bg_ground dut (
    .clk         (clk),
    .rst         (rst),
    .i_hpos      (hpos),
    .i_vpos      (vpos),
    .i_frame_tick(tick),
    .i_run       (run),
    .i_restart   (restart),
    .i_speed     (speed),
    .o_color_bg  (color),
    .o_scroll    (scroll)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask
  initial begin
    rst = 1'b0; tick = 1'b1; run = 1'b0; restart = 1'b0; speed = '0;
    hpos = '0; vpos = 10'd200;
    step(); step();
    check("rst_color", 32'(color), 0);
    check("rst_scroll", 32'(scroll), 0);
    rst = 1'b1;
    step(); step();
    check("release_tick_high", 32'(scroll), 0);
    tick = 1'b0;
    for (int h = 0; h < 640; h++) begin
      hpos = 10'(h);
      step();
      check("horizon", 32'(color), 1);
    end
    vpos = 10'd199; step(); check("row199", 32'(color), 0);
    vpos = 10'd203; step(); check("row203", 32'(color), 0);
    vpos = 10'd202; hpos = 10'd5; step(); check("row202_scroll0", 32'(color), 32'(TEX));
    run = 1'b1; speed = 5'd6;
    step();
    repeat (3) pulse();
    check("subpixel_3edges", 32'(scroll), 4);
    tick = 1'b1;
    repeat (10) step();
    tick = 1'b0;
    step();
    check("held_tick_once", 32'(scroll), 6);
    restart = 1'b1; step(); restart = 1'b0;
    check("restart_clear", 32'(scroll), 0);
    step();
    speed = 5'd12;
    repeat (11) pulse();
    check("wrap_33px", 32'(scroll), 1);
    run = 1'b0; step();
    repeat (5) pulse();
    check("idle_holds", 32'(scroll), 1);
    run = 1'b1; tick = 1'b1; step(); tick = 1'b0; step();
    check("edge_on_run_rise", 32'(scroll), 1);
    pulse();
    check("run_after_rise", 32'(scroll), 4);
    tick = 1'b1; restart = 1'b1; step(); restart = 1'b0; tick = 1'b0;
    check("restart_beats_edge", 32'(scroll), 0);
    step();
    pulse();
    check("run_after_restart", 32'(scroll), 3);
    restart = 1'b1; step(); restart = 1'b0;
    pulse();
    check("idle_after_restart", 32'(scroll), 0);
    pulse();
    check("scroll_for_texture", 32'(scroll), 3);
    vpos = 10'd201; hpos = 10'd2; step(); check("tex_u5", 32'(color), 32'(TEX));
    hpos = 10'd3; step(); check("tex_u6", 32'(color), 0);
    hpos = 10'd34; step(); check("tex_wrap_u5", 32'(color), 32'(TEX));
    vpos = 10'd202; hpos = 10'd7; step(); check("tex_row1_u10", 32'(color), 32'(TEX));
    hpos = 10'd8; step(); check("tex_row1_u11", 32'(color), 0);
    vpos = 10'd200; step();
    rst = 1'b0; step();
    check("midframe_rst_color", 32'(color), 0);
    check("midframe_rst_scroll", 32'(scroll), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
